// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
// Contents: op encodings, FSM state enum, iteration mode, iteration count and helper predicates.
package mdu_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [2:0] MDU_MUL  = 3'b000;
  localparam logic [2:0] MDU_MULH = 3'b001;
  localparam logic [2:0] MDU_DIV  = 3'b010;
  localparam logic [2:0] MDU_DIVU = 3'b011;
  localparam logic [2:0] MDU_REM  = 3'b100;
  localparam logic [2:0] MDU_REMU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } mode_t;

  function automatic logic op_is_div(input logic [2:0] code);
    return (code == MDU_DIV) || (code == MDU_DIVU) ||
           (code == MDU_REM) || (code == MDU_REMU);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] code);
    return (code == MDU_REM) || (code == MDU_REMU);
  endfunction

  // Ops whose operands are treated as two's complement and iterated on magnitudes.
  // MUL is absent: the low product word is identical for signed and unsigned inputs.
  function automatic logic op_is_signed(input logic [2:0] code);
    return (code == MDU_MULH) || (code == MDU_DIV) || (code == MDU_REM);
  endfunction

  function automatic logic op_is_reserved(input logic [2:0] code);
    return code > MDU_REMU;
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of shift-add multiply or restoring divide.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register acc_next.
// Ports: mode (mul/div), acc (2*WIDTH working register), operand (multiplicand or divisor),
//        acc_next (updated working register), q_bit (quotient bit produced in div mode).
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mode_t              mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    mul_sum  = '0;
    rem_sh   = '0;
    diff     = '0;
    acc_next = '0;
    q_bit    = 1'b0;
    if (mode == MODE_MUL) begin
      // acc = {partial product, remaining multiplier bits}; add on LSB, shift right with carry.
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else begin
      // acc = {remainder, remaining dividend bits}; shift left one, trial subtract.
      // The shifted remainder needs WIDTH+1 bits; the borrow bit says whether it fit.
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      diff     = rem_sh - {1'b0, operand};
      q_bit    = ~diff[WIDTH];
      // Quotient bit slot is left 0 here and OR'd in by the caller from q_bit.
      acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// RV32M multi-cycle multiply/divide sequencer: FSM, counter, sign handling, result register.
// Latency: 35 cycles accept-to-done on iterative ops, 2 cycles on fast paths (div by 0, overflow, reserved).
// Backpressure: stall holds the PC from the accepting cycle until the cycle before done; start while busy is ignored.
// Ports: start/op/rs1/rs2 from decode, kill flushes the op; stall/busy/done/result to pipeline and writeback.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             kill,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               neg_a;
  logic               neg_b;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;

  logic               accept;
  logic               sgn;
  logic               a_neg_c;
  logic               b_neg_c;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               fast;
  logic [WIDTH-1:0]   fast_val;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   fix_val;
  mode_t              mode;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;

  assign accept = start & ~kill & (state == ST_IDLE);
  assign busy   = (state == ST_PREP) | (state == ST_CALC) | (state == ST_FIX);
  assign done   = (state == ST_DONE);
  assign stall  = accept | busy;
  assign mode   = op_is_div(op_q) ? MODE_DIV : MODE_MUL;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .mode     (mode),
    .acc      (acc),
    .operand  (b_q),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Sign capture and magnitudes, consumed in PREP from the latched operands.
  always_comb begin
    sgn     = op_is_signed(op_q);
    a_neg_c = sgn & a_q[WIDTH-1];
    b_neg_c = sgn & b_q[WIDTH-1];
    a_mag   = a_neg_c ? -a_q : a_q;
    b_mag   = b_neg_c ? -b_q : b_q;
  end

  // Cases resolved without iterating; div-by-zero takes priority over overflow.
  always_comb begin
    fast     = 1'b0;
    fast_val = '0;
    if (op_is_reserved(op_q)) begin
      fast     = 1'b1;
      fast_val = '0;
    end else if (op_is_div(op_q) && (b_q == '0)) begin
      fast     = 1'b1;
      fast_val = op_is_rem(op_q) ? a_q : '1;
    end else if (((op_q == MDU_DIV) || (op_q == MDU_REM)) && (a_q == INT_MIN) && (b_q == '1)) begin
      fast     = 1'b1;
      fast_val = (op_q == MDU_DIV) ? INT_MIN : '0;
    end
  end

  // Output word selection and sign restoration after CALC.
  always_comb begin
    prod_signed = (neg_a ^ neg_b) ? -acc : acc;
    case (op_q)
      MDU_MULH: fix_val = prod_signed[2*WIDTH-1:WIDTH];
      MDU_DIV:  fix_val = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      MDU_DIVU: fix_val = acc[WIDTH-1:0];
      MDU_REM:  fix_val = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      MDU_REMU: fix_val = acc[2*WIDTH-1:WIDTH];
      default:  fix_val = acc[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_PREP;
      ST_PREP: state_nxt = fast ? ST_DONE : ST_CALC;
      ST_CALC: if (count == CNT_W'(ITER - 1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (kill) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op;
            a_q  <= rs1;
            b_q  <= rs2;
          end
        end
        ST_PREP: begin
          neg_a <= a_neg_c;
          neg_b <= b_neg_c;
          // Upper half cleared; the magnitude of A seeds the multiplier/dividend half.
          acc   <= {{WIDTH{1'b0}}, a_mag};
          b_q   <= b_mag;
          count <= '0;
          if (fast && !kill) result <= fast_val;
        end
        ST_CALC: begin
          acc   <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
          count <= count + 1'b1;
        end
        ST_FIX: begin
          if (!kill) result <= fix_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq with hand-computed results and latencies.
// Latency: N/A (testbench).
// Backpressure: N/A (testbench).
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  mdu_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .kill   (kill),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in an idle cycle (cycle N) and waits for done. lat = k where done is
  // seen in cycle N+k, or -1 on timeout. stall_ok covers stall high N..N+lat-1 and low in DONE.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res,
                        output bit stall_ok, output bit extra_done);
    lat = -1;
    res = 32'h0;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    #1;
    stall_ok = (stall === 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (done === 1'b1) begin
        lat = k;
        res = result;
        if (stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
      tick();
    end
    tick();
    extra_done = (done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'b000; rs1 = '0; rs2 = '0;
    #12;
    checks++; if (stall !== 1'b0)  begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", result); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    int lat; logic [31:0] r; bit s_ok, xd;
    run_op(MDU_MUL, 32'd7, 32'hFFFF_FFFD, lat, r, s_ok, xd);
    checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result: got %h expected ffffffeb", r); end
    checks++; if (lat != 35) begin failures++; $display("FAIL mul_latency: got %0d expected 35", lat); end
    checks++; if (!s_ok) begin failures++; $display("FAIL mul_stall_window: got wrong stall expected high N..N+34 low in DONE"); end
    checks++; if (xd) begin failures++; $display("FAIL mul_done_pulse: got done=1 after DONE expected 0"); end
  endtask

  task automatic test_mulh();
    int lat; logic [31:0] r; bit s_ok, xd;
    run_op(MDU_MULH, 32'h8000_0000, 32'h8000_0000, lat, r, s_ok, xd);
    checks++; if (r !== 32'h4000_0000) begin failures++; $display("FAIL mulh_minmin: got %h expected 40000000", r); end
    checks++; if (lat != 35) begin failures++; $display("FAIL mulh_minmin_latency: got %0d expected 35", lat); end
    run_op(MDU_MULH, 32'hFFFF_FFFF, 32'h0000_0002, lat, r, s_ok, xd);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulh_neg: got %h expected ffffffff", r); end
  endtask

  task automatic test_div_signed();
    int lat; logic [31:0] r; bit s_ok, xd;
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, lat, r, s_ok, xd);
    checks++; if (r !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg: got %h expected fffffffd", r); end
    checks++; if (lat != 35) begin failures++; $display("FAIL div_neg_latency: got %0d expected 35", lat); end
    run_op(MDU_REM, 32'hFFFF_FFF9, 32'd2, lat, r, s_ok, xd);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_neg: got %h expected ffffffff", r); end
  endtask

  task automatic test_div_unsigned();
    int lat; logic [31:0] r; bit s_ok, xd;
    run_op(MDU_DIVU, 32'd100, 32'd7, lat, r, s_ok, xd);
    checks++; if (r !== 32'd14) begin failures++; $display("FAIL divu: got %h expected 0000000e", r); end
    run_op(MDU_REMU, 32'd100, 32'd7, lat, r, s_ok, xd);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL remu: got %h expected 00000002", r); end
    checks++; if (!s_ok) begin failures++; $display("FAIL remu_stall_window: got wrong stall expected high N..N+34 low in DONE"); end
  endtask

  // Relies on the previous op (REMU 100/7) leaving result = 2.
  task automatic test_kill();
    int lat; logic [31:0] r; bit s_ok, xd; bit saw_done;
    saw_done = 1'b0;
    start = 1'b1; op = MDU_MUL; rs1 = 32'd5; rs2 = 32'd6;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    kill = 1'b1;
    #1;
    if (done === 1'b1) saw_done = 1'b1;
    tick();
    kill = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL kill_idle_busy: got %b expected 0", busy); end
    checks++; if (stall !== 1'b0)  begin failures++; $display("FAIL kill_idle_stall: got %b expected 0", stall); end
    checks++; if (result !== 32'd2) begin failures++; $display("FAIL kill_result_held: got %h expected 00000002", result); end
    for (int k = 0; k < 5; k++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++; if (saw_done) begin failures++; $display("FAIL kill_no_done: got done=1 expected 0"); end
    run_op(MDU_DIVU, 32'd9, 32'd3, lat, r, s_ok, xd);
    checks++; if (r !== 32'd3) begin failures++; $display("FAIL kill_then_divu: got %h expected 00000003", r); end
    checks++; if (lat != 35) begin failures++; $display("FAIL kill_then_divu_latency: got %0d expected 35", lat); end
  endtask

  task automatic test_start_ignored();
    int dones; int first;
    dones = 0; first = -1;
    start = 1'b1; op = MDU_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin start = 1'b1; op = MDU_MUL; rs1 = 32'd3; rs2 = 32'd3; end
      if (k == 36) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first < 0) first = k;
      end
      tick();
    end
    checks++; if (dones != 1)  begin failures++; $display("FAIL start_ignored_count: got %0d dones expected 1", dones); end
    checks++; if (first != 35) begin failures++; $display("FAIL start_ignored_latency: got %0d expected 35", first); end
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL start_ignored_result: got %h expected 0000000e", result); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_ignored_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] r; bit s_ok, xd;
    run_op(MDU_DIVU, 32'd5, 32'd0, lat, r, s_ok, xd);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_by_zero: got %h expected ffffffff", r); end
    checks++; if (lat != 2) begin failures++; $display("FAIL divu_by_zero_latency: got %0d expected 2", lat); end
    checks++; if (!s_ok) begin failures++; $display("FAIL divu_by_zero_stall: got wrong stall expected high N..N+1 low in DONE"); end
    run_op(MDU_REMU, 32'd5, 32'd0, lat, r, s_ok, xd);
    checks++; if (r !== 32'd5) begin failures++; $display("FAIL remu_by_zero: got %h expected 00000005", r); end
    checks++; if (lat != 2) begin failures++; $display("FAIL remu_by_zero_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] r; bit s_ok, xd;
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, s_ok, xd);
    checks++; if (r !== 32'h8000_0000) begin failures++; $display("FAIL div_overflow: got %h expected 80000000", r); end
    checks++; if (lat != 2) begin failures++; $display("FAIL div_overflow_latency: got %0d expected 2", lat); end
    run_op(MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, r, s_ok, xd);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rem_overflow: got %h expected 00000000", r); end
    checks++; if (lat != 2) begin failures++; $display("FAIL rem_overflow_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] r; bit s_ok, xd; bit saw_done;
    saw_done = 1'b0;
    run_op(MDU_MUL, 32'd6, 32'd7, lat, r, s_ok, xd);
    checks++; if (r !== 32'd42) begin failures++; $display("FAIL mul_small: got %h expected 0000002a", r); end
    start = 1'b1; op = MDU_MUL; rs1 = 32'd3; rs2 = 32'd5;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL arst_busy: got %b expected 0", busy); end
    checks++; if (stall !== 1'b0)  begin failures++; $display("FAIL arst_stall: got %b expected 0", stall); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL arst_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL arst_result: got %h expected 00000000", result); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++; if (saw_done) begin failures++; $display("FAIL arst_no_done: got done=1 expected 0"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_idle: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div_signed();
    test_div_unsigned();
    test_kill();
    test_start_ignored();
    test_div_zero();
    test_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle sequencer and iterative datapath for the RV32M multiply/divide unit. It accepts an operation from the instruction decoder when an M-extension R-type instruction is decoded. It stalls PC advance while it runs iterative shift-add multiply or restoring divide, then presents a 32-bit result for writeback on the MDU writeback path (WBsel = 3).

## Interface
- `WIDTH`, default 32: operand/result width. Only 32 is supported.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: decoder reports an MDU instruction this cycle.
- `op` in 3: 000 MUL, 001 MULH, 010 DIV, 011 DIVU, 100 REM, 101 REMU, 110/111 reserved.
- `rs1` in WIDTH: operand A, sampled on the accepting edge only.
- `rs2` in WIDTH: operand B, sampled on the accepting edge only.
- `kill` in 1: abort the in-flight operation (pipeline flush).
- `stall` out 1: hold PC/instruction. Combinational: `(start & ~kill & state==IDLE) | busy`.
- `busy` out 1: high in PREP, CALC, FIX.
- `done` out 1: one-cycle pulse in DONE; `result` is valid and RegWEn may fire.
- `result` out WIDTH: registered; holds the last value until the next DONE.

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE: if `start & ~kill`, latch `op`, `rs1`, `rs2` and go to PREP. Otherwise stay.
- PREP:
  - Record the operand signs for signed ops (MULH, DIV, REM) and take absolute values.
  - Clear the 64-bit accumulator/remainder and set count = 0.
  - Fast paths go directly to DONE with the result loaded:
    - rs2 == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
    - rs1 == 0x80000000 and rs2 == 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
    - Reserved op: result 0.
  - All other cases go to CALC.
- CALC runs exactly 32 cycles, one iteration per cycle, count 0..31. Exit to FIX after count == 31.
  - MUL/MULH: radix-2 shift-add producing an unsigned 64-bit product of the magnitudes.
  - DIV/DIVU/REM/REMU: restoring division (shift remainder, trial subtract, set quotient bit).
- FIX applies signs and selects the output word:
  - MULH: negate the 64-bit product if the signs differ, then take the upper 32 bits.
  - MUL: lower 32 bits. No sign fix is needed.
  - DIV: negate the quotient if the signs differ.
  - REM: the remainder takes the dividend's sign.
  - Go to DONE.
- DONE: assert `done`, then go unconditionally to IDLE. `start` is ignored in DONE, because the same instruction is still presented in that cycle.
- `start` while busy is ignored.
- `kill` in any state: next state is IDLE, no `done`, `result` unchanged. `kill` and `start` together in IDLE: kill wins, nothing is accepted.
- Reset values: state IDLE, count 0, `result` 0, `done` 0, `busy` 0, internal registers 0.
- Reset asserted mid-operation: the operation is abandoned immediately and `done` is not asserted.

## Timing
- `start` accepted in cycle N. PREP in N+1.
- Normal path: CALC N+2..N+33, FIX N+34, DONE (`done` = 1) in N+35. Latency is 35 cycles.
- Fast path: DONE in N+2.
- `stall` is high from N through the cycle before DONE. It is low in DONE so the core writes back and advances at the end of that cycle.
- The earliest next accept is the cycle after DONE.

## Structure
- `mdu_pkg` holds:
  - The op encodings (MDU_MUL … MDU_REMU).
  - The state enum.
  - ITER = 32 and the counter width $clog2(ITER).
- Sub-module `mdu_iter_step` is a purely combinational single iteration. It takes {mode, acc, operand} and returns the next acc plus the quotient bit. It is instantiated once inside `mdu_seq`.
- The FSM, counter, sign bookkeeping and output register stay in `mdu_seq`.

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD (−3), start at N → `done` at N+35, result 0xFFFFFFEB. `stall` is high N..N+34.
- MULH, 0x80000000 × 0x80000000 → 0x40000000. MULH, 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both with `done` at N+2. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, both at N+2.
- `kill` at N+10 → IDLE at N+11, no `done`, `result` keeps its prior value. A new DIVU 9/3 then gives 3 after 35 cycles.
- `start` pulsed at N+5 and held high through DONE → ignored, exactly one `done`. Async `rst_n` low mid-CALC → all outputs 0 immediately, FSM in IDLE.
